// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory port arbiter and
// other word-addressed memory controllers.
package imem_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } imem_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Byte address is legal when word-aligned and its word index fits in 2**addr_w.
  function automatic logic addr_legal(input logic [31:0] byte_addr, input int addr_w);
    logic [31:0] word_addr;
    word_addr = {2'b00, byte_addr[31:2]};
    return (byte_addr[1:0] == 2'b00) && ((word_addr >> addr_w) == 32'd0);
  endfunction

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Fetch, loader, status and memory-side signals of the instruction-memory arbiter.
// slave is the arbiter side; master is the requester/memory side.
interface imem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);

  logic              fetch_req;
  logic [31:0]       fetch_pc;
  logic              fetch_gnt;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_instr;
  logic              fetch_err;

  logic              load_req;
  logic [31:0]       load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_gnt;
  logic              load_err;
  logic              load_done;
  logic [ADDR_W:0]   load_count;
  logic              boot_ready;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  fetch_req, fetch_pc, load_req, load_addr, load_data, load_done, mem_rdata,
    output fetch_gnt, fetch_valid, fetch_instr, fetch_err,
    output load_gnt, load_err, load_count, boot_ready,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output fetch_req, fetch_pc, load_req, load_addr, load_data, load_done, mem_rdata,
    input  fetch_gnt, fetch_valid, fetch_instr, fetch_err,
    input  load_gnt, load_err, load_count, boot_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_rr_arb.sv
// Two-requester round-robin arbiter; when disabled only the loader is served.
module imem_rr_arb (
  input  logic clk,
  input  logic reset_n,
  input  logic en_i,
  input  logic fetch_req_i,
  input  logic load_req_i,
  output logic fetch_gnt_o,
  output logic load_gnt_o
);

  // 1: fetch was granted most recently, 0: loader was.
  logic fetch_last_q;

  always_comb begin
    fetch_gnt_o = 1'b0;
    load_gnt_o  = 1'b0;
    if (!en_i) begin
      load_gnt_o = load_req_i;
    end else if (fetch_req_i && load_req_i) begin
      fetch_gnt_o = !fetch_last_q;
      load_gnt_o  = fetch_last_q;
    end else begin
      fetch_gnt_o = fetch_req_i;
      load_gnt_o  = load_req_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_last_q <= 1'b0;
    end else if (fetch_gnt_o) begin
      fetch_last_q <= 1'b1;
    end else if (load_gnt_o) begin
      fetch_last_q <= 1'b0;
    end
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares a single-port instruction memory between the program loader and the
// fetch stage: loader-only BOOT phase, then round-robin RUN phase.
module imem_port_arbiter
  import imem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input logic               clk,
  input logic               reset_n,
  imem_port_arbiter_if.slave bus
);

  localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  imem_state_e     state_q;
  logic            boot_ready_q;
  logic            fetch_valid_q;
  logic            fetch_err_q;
  logic            load_err_q;
  logic [ADDR_W:0] load_count_q;

  logic fetch_gnt;
  logic load_gnt;
  logic fetch_ok;
  logic load_ok;

  assign fetch_ok = addr_legal(bus.fetch_pc, ADDR_W);
  assign load_ok  = addr_legal(bus.load_addr, ADDR_W);

  imem_rr_arb u_arb (
    .clk         (clk),
    .reset_n     (reset_n),
    .en_i        (state_q == RUN),
    .fetch_req_i (bus.fetch_req),
    .load_req_i  (bus.load_req),
    .fetch_gnt_o (fetch_gnt),
    .load_gnt_o  (load_gnt)
  );

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (load_gnt && load_ok) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_addr  = bus.load_addr[ADDR_W+1:2];
      bus.mem_wdata = bus.load_data;
    end else if (fetch_gnt && fetch_ok) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = bus.fetch_pc[ADDR_W+1:2];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= BOOT;
      boot_ready_q <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          if (bus.load_done) begin
            state_q      <= RUN;
            boot_ready_q <= 1'b1;
          end
        end
        RUN: begin
          state_q      <= RUN;
          boot_ready_q <= 1'b1;
        end
        default: begin
          state_q      <= BOOT;
          boot_ready_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      load_err_q    <= 1'b0;
      load_count_q  <= '0;
    end else begin
      fetch_valid_q <= fetch_gnt;
      fetch_err_q   <= fetch_gnt && !fetch_ok;
      load_err_q    <= load_gnt && !load_ok;
      if (load_gnt && load_ok && (load_count_q != COUNT_MAX)) begin
        load_count_q <= load_count_q + 1'b1;
      end
    end
  end

  // Legal reads return the memory data directly; it arrives in the valid cycle.
  assign bus.fetch_instr = fetch_valid_q ? (fetch_err_q ? DATA_W'(NOP_INSTR) : bus.mem_rdata)
                                         : '0;
  assign bus.fetch_gnt   = fetch_gnt;
  assign bus.load_gnt    = load_gnt;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_err   = fetch_err_q;
  assign bus.load_err    = load_err_q;
  assign bus.load_count  = load_count_q;
  assign bus.boot_ready  = boot_ready_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a behavioural single-port memory.
module tb_imem_port_arbiter;

  logic clk;
  logic reset_n;
  int   n_chk;
  int   n_pass;

  imem_port_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  imem_port_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [31:0] mem_model [256];

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) mem_model[bus.mem_addr] <= bus.mem_wdata;
    else if (bus.mem_en) bus.mem_rdata <= mem_model[bus.mem_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    reset_n = 1'b0;
    bus.fetch_req = 1'b0;
    bus.fetch_pc = 32'h0;
    bus.load_req = 1'b0;
    bus.load_addr = 32'h0;
    bus.load_data = 32'h0;
    bus.load_done = 1'b0;
    bus.mem_rdata = 32'h0;

    // Reset values
    #12;
    check("rst_fetch_valid", bus.fetch_valid, 0);
    check("rst_fetch_err", bus.fetch_err, 0);
    check("rst_fetch_instr", bus.fetch_instr, 0);
    check("rst_load_err", bus.load_err, 0);
    check("rst_load_count", bus.load_count, 0);
    check("rst_boot_ready", bus.boot_ready, 0);
    check("rst_mem_en", bus.mem_en, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Boot load with fetch held high: fetch stalled
    bus.fetch_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.load_req = 1'b1;
      bus.load_addr = 32'(i * 4);
      bus.load_data = 32'hA000_0000 + 32'(i);
      #1;
      check("boot_fetch_gnt", bus.fetch_gnt, 0);
      check("boot_load_gnt", bus.load_gnt, 1);
      check("boot_mem_we", bus.mem_we, 1);
      check("boot_mem_addr", bus.mem_addr, 64'(i));
    end
    @(negedge clk);
    bus.load_req = 1'b0;
    #1;
    check("boot_fetch_stall", bus.fetch_gnt, 0);
    check("boot_load_count", bus.load_count, 4);
    check("boot_not_ready", bus.boot_ready, 0);

    bus.load_done = 1'b1;
    @(negedge clk);
    bus.load_done = 1'b0;
    bus.fetch_req = 1'b0;
    #1;
    check("boot_ready_rise", bus.boot_ready, 1);

    // Legal fetch of 0x8
    @(negedge clk);
    bus.fetch_req = 1'b1;
    bus.fetch_pc = 32'h8;
    #1;
    check("f8_gnt", bus.fetch_gnt, 1);
    check("f8_mem_en", bus.mem_en, 1);
    check("f8_mem_we", bus.mem_we, 0);
    check("f8_mem_addr", bus.mem_addr, 2);
    @(negedge clk);
    bus.fetch_req = 1'b0;
    #1;
    check("f8_valid", bus.fetch_valid, 1);
    check("f8_err", bus.fetch_err, 0);
    check("f8_instr", bus.fetch_instr, 32'hA000_0002);

    // Misaligned fetch of 0x6
    @(negedge clk);
    bus.fetch_req = 1'b1;
    bus.fetch_pc = 32'h6;
    #1;
    check("f6_gnt", bus.fetch_gnt, 1);
    check("f6_mem_en", bus.mem_en, 0);
    @(negedge clk);
    bus.fetch_req = 1'b0;
    #1;
    check("f6_valid", bus.fetch_valid, 1);
    check("f6_err", bus.fetch_err, 1);
    check("f6_instr", bus.fetch_instr, 32'h0000_0013);
    @(negedge clk);
    #1;
    check("f6_valid_pulse", bus.fetch_valid, 0);

    // Out-of-range load to 0x400
    @(negedge clk);
    bus.load_req = 1'b1;
    bus.load_addr = 32'h400;
    bus.load_data = 32'hDEAD_BEEF;
    #1;
    check("l400_gnt", bus.load_gnt, 1);
    check("l400_mem_en", bus.mem_en, 0);
    @(negedge clk);
    bus.load_req = 1'b0;
    #1;
    check("l400_err", bus.load_err, 1);
    check("l400_count", bus.load_count, 4);
    @(negedge clk);
    #1;
    check("l400_err_pulse", bus.load_err, 0);

    // Contention: loader won last, so fetch first
    @(negedge clk);
    bus.fetch_req = 1'b1;
    bus.fetch_pc = 32'h0;
    bus.load_req = 1'b1;
    bus.load_addr = 32'h10;
    bus.load_data = 32'hA000_0004;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      check("rr_fetch_gnt", bus.fetch_gnt, (i % 2 == 0) ? 1 : 0);
      check("rr_load_gnt", bus.load_gnt, (i % 2 == 0) ? 0 : 1);
    end
    @(negedge clk);
    bus.fetch_req = 1'b0;
    bus.load_req = 1'b0;
    #1;
    check("rr_load_count", bus.load_count, 6);

    // Saturation: 260 further legal writes from count 6
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      bus.load_req = 1'b1;
      bus.load_addr = 32'((i % 256) * 4);
      bus.load_data = 32'hB000_0000 + 32'(i);
      if (i == 249) begin
        #1;
        check("sat_count_255", bus.load_count, 255);
      end
    end
    @(negedge clk);
    bus.load_req = 1'b0;
    #1;
    check("sat_count", bus.load_count, 256);

    // Reset during a pending read
    @(negedge clk);
    bus.fetch_req = 1'b1;
    bus.fetch_pc = 32'h8;
    #1;
    check("mr_gnt", bus.fetch_gnt, 1);
    #2;
    reset_n = 1'b0;
    bus.fetch_req = 1'b0;
    #1;
    check("mr_valid_in_rst", bus.fetch_valid, 0);
    check("mr_boot_ready", bus.boot_ready, 0);
    check("mr_count", bus.load_count, 0);
    @(posedge clk);
    #1;
    check("mr_valid_after_edge", bus.fetch_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    bus.fetch_req = 1'b1;
    bus.fetch_pc = 32'h0;
    #1;
    check("mr_boot_stall", bus.fetch_gnt, 0);
    @(posedge clk);
    #1;
    check("mr_valid_first", bus.fetch_valid, 0);

    // load_done together with load_req in BOOT
    @(negedge clk);
    bus.fetch_req = 1'b0;
    bus.load_req = 1'b1;
    bus.load_addr = 32'h20;
    bus.load_data = 32'hC0FF_EE00;
    bus.load_done = 1'b1;
    #1;
    check("ld_gnt", bus.load_gnt, 1);
    check("ld_mem_we", bus.mem_we, 1);
    check("ld_mem_addr", bus.mem_addr, 8);
    @(negedge clk);
    bus.load_req = 1'b0;
    bus.load_done = 1'b0;
    #1;
    check("ld_boot_ready", bus.boot_ready, 1);
    check("ld_count", bus.load_count, 1);
    @(negedge clk);
    bus.fetch_req = 1'b1;
    bus.fetch_pc = 32'h20;
    #1;
    check("ld_fetch_gnt", bus.fetch_gnt, 1);
    @(negedge clk);
    bus.fetch_req = 1'b0;
    #1;
    check("ld_fetch_instr", bus.fetch_instr, 32'hC0FF_EE00);
    check("ld_fetch_err", bus.fetch_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
